// File: rtl/prio_enc_serializer.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc_serializer
// Purpose  : Collects request bits from N lines into a pending register and
//            emits them one encoded index per handshake, highest priority
//            first. Back-pressure on the output never loses a request.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   N          number of request lines (2..64)
//   IW         index width, $clog2(N)                 (derived)
//   CW         pending-count width, $clog2(N+1)       (derived)
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous active-high reset
//   req_in     request vector, bit k requests index k
//   EN_enc     capture strobe, ORs req_in into the pending register
//   RDY_enc    capture accepted (low in every reset cycle)
//   out_valid  out_idx holds a valid index
//   out_idx    granted index
//   out_last   nothing else was pending when this index was loaded
//   out_ready  consumer accepts out_idx this cycle
//   pend_count population count of the pending register
// Configuration macro:
//   PENC_RR_EN defined   -> round-robin priority (descending from ptr, wraps)
//   PENC_RR_EN undefined -> fixed priority, highest index wins
// ============================================================================
module prio_enc_serializer #(
    parameter  int N  = 8,
    localparam int IW = $clog2(N),
    localparam int CW = $clog2(N + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [N-1:0]  req_in,
    input  logic          EN_enc,
    output logic          RDY_enc,
    output logic          out_valid,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    input  logic          out_ready,
    output logic [CW-1:0] pend_count
);

    logic [N-1:0]  r_pending;
    logic          r_valid;
    logic [IW-1:0] r_idx;
    logic          r_last;

    logic [N-1:0]  w_cap_vec;
    logic          w_load;
    logic          w_any;
    logic [IW-1:0] w_sel;
    logic [N-1:0]  w_onehot;
    logic [N-1:0]  w_clr;
    logic [N-1:0]  w_rest;
    logic [CW-1:0] w_count;

    // Captures are refused only while reset is asserted.
    assign RDY_enc   = ~RST;
    assign w_cap_vec = (EN_enc && RDY_enc) ? req_in : '0;
    assign w_load    = ~r_valid | out_ready;

`ifdef PENC_RR_EN
    logic [IW-1:0] r_ptr;

    // Index reached k steps below p, wrapping from 0 back to N-1.
    function automatic int wrap_down(input int p, input int k);
        return (k <= p) ? (p - k) : (p + N - k);
    endfunction

    // Round-robin: the first set bit found descending from r_ptr wins.
    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_any && r_pending[wrap_down(int'(r_ptr), k)]) begin
                w_sel = IW'(wrap_down(int'(r_ptr), k));
                w_any = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr <= IW'(N - 1);
        end else if (w_load && w_any) begin
            r_ptr <= (w_sel == '0) ? IW'(N - 1) : (w_sel - IW'(1));
        end
    end
`else
    // Fixed priority: ascending scan, so the last (highest) set bit wins.
    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (r_pending[k]) begin
                w_sel = IW'(k);
                w_any = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_onehot        = '0;
        w_onehot[w_sel] = 1'b1;
    end

    // Only a real load clears the selected bit; a same-cycle capture of that
    // bit is ORed in afterwards so the set wins.
    assign w_clr  = (w_load && w_any) ? w_onehot : '0;
    assign w_rest = (r_pending & ~w_onehot) | w_cap_vec;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_last    <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_cap_vec;
            if (w_load) begin
                if (w_any) begin
                    r_valid <= 1'b1;
                    r_idx   <= w_sel;
                    r_last  <= (w_rest == '0);
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_count = '0;
        for (int k = 0; k < N; k++) begin
            w_count = w_count + CW'(r_pending[k]);
        end
    end

    assign out_valid  = r_valid;
    assign out_idx    = r_idx;
    assign out_last   = r_last;
    assign pend_count = w_count;

endmodule
`default_nettype wire

// File: tb/tb_prio_enc_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_enc_serializer
// Purpose  : Self-checking bench for prio_enc_serializer (N=8). A behavioural
//            model tracks the pending set and output register; a negedge
//            process compares every cycle, and directed scenarios pin the
//            model with hand-computed values. Randomized traffic follows.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prio_enc_serializer;

    localparam int N = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] req_in;
    logic       EN_enc;
    logic       RDY_enc;
    logic       out_valid;
    logic [2:0] out_idx;
    logic       out_last;
    logic       out_ready;
    logic [3:0] pend_count;

    int checks   = 0;
    int failures = 0;

    prio_enc_serializer #(.N(N)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req_in     (req_in),
        .EN_enc     (EN_enc),
        .RDY_enc    (RDY_enc),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .pend_count (pend_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_pend  = '0;
    logic       m_valid = 1'b0;
    int         m_idx   = 0;
    logic       m_last  = 1'b0;
    int         m_ptr   = N - 1;
    logic       m_init  = 1'b0;

    logic [7:0] m_cap;
    logic [7:0] m_rest;
    int         m_sel;

    // Which pending index is granted next; -1 when nothing is pending.
    function automatic int pick(input logic [7:0] p, input int ptr);
`ifdef PENC_RR_EN
        for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr - k + N) % N;
            if (p[i]) return i;
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (p[i]) return i;
        end
`endif
        return -1;
    endfunction

    always_comb begin
        m_cap  = (EN_enc && !RST) ? req_in : 8'h00;
        m_sel  = pick(m_pend, m_ptr);
        m_rest = (m_sel >= 0) ? ((m_pend & ~(8'h01 << m_sel)) | m_cap) : m_cap;
    end

    always @(posedge CLK) begin
        if (RST) begin
            m_pend  <= '0;
            m_valid <= 1'b0;
            m_idx   <= 0;
            m_last  <= 1'b0;
            m_ptr   <= N - 1;
            m_init  <= 1'b1;
        end else if ((!m_valid || out_ready) && m_sel >= 0) begin
            m_valid <= 1'b1;
            m_idx   <= m_sel;
            m_last  <= (m_rest == 8'h00);
            m_ptr   <= (m_sel == 0) ? N - 1 : m_sel - 1;
            m_pend  <= m_rest;
        end else begin
            if (!m_valid || out_ready) m_valid <= 1'b0;
            m_pend <= m_pend | m_cap;
        end
    end

    always @(negedge CLK) begin
        if (m_init) begin
            check("rdy",        RDY_enc,    !RST);
            check("valid",      out_valid,  m_valid);
            check("idx",        out_idx,    m_idx);
            check("last",       out_last,   m_last);
            check("pend_count", pend_count, $countones(m_pend));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    int bexp[3]  = '{7, 2, 0};
    int bpexp[4] = '{7, 2, 1, 0};
    int cur;
    int prev;

    initial begin
        RST = 1'b1; EN_enc = 1'b1; req_in = 8'hFF; out_ready = 1'b0;

        // Reset holds everything low and ignores the capture strobe.
        @(posedge CLK);
        @(negedge CLK);
        check("rst_valid", out_valid, 0);
        check("rst_idx",   out_idx,   0);
        check("rst_count", pend_count, 0);
        check("rst_rdy",   RDY_enc,   0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0; EN_enc = 1'b0; req_in = 8'h00;
        @(negedge CLK);
        check("post_rst_rdy", RDY_enc, 1);
        repeat (3) begin
            @(negedge CLK);
            check("post_rst_idle", out_valid, 0);
        end

        // Single request at index 5, held under back-pressure, then consumed.
        tick(); req_in = 8'h20; EN_enc = 1'b1; out_ready = 1'b0;
        tick(); EN_enc = 1'b0; req_in = 8'h00;
        @(negedge CLK);
        check("single_pend", pend_count, 1);
        check("single_notyet", out_valid, 0);
        tick();
        @(negedge CLK);
        check("single_valid", out_valid, 1);
        check("single_idx",   out_idx,   5);
        check("single_last",  out_last,  1);
        repeat (3) tick();
        @(negedge CLK);
        check("single_hold_valid", out_valid, 1);
        check("single_hold_idx",   out_idx,   5);
        tick(); out_ready = 1'b1;
        tick(); out_ready = 1'b0;
        @(negedge CLK);
        check("single_done", out_valid, 0);

        // Burst 8'b1000_0101 drained back to back.
        tick(); req_in = 8'h85; EN_enc = 1'b1; out_ready = 1'b1;
        tick(); EN_enc = 1'b0; req_in = 8'h00;
        @(negedge CLK);
        check("burst_count3", pend_count, 3);
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge CLK);
            check("burst_valid", out_valid, 1);
            check("burst_idx",   out_idx,   bexp[k]);
            check("burst_last",  out_last,  (k == 2));
            check("burst_count", pend_count, 2 - k);
        end
        tick();
        @(negedge CLK);
        check("burst_done", out_valid, 0);

        // Back-pressure with a late capture that re-requests the held index.
        tick(); req_in = 8'h85; EN_enc = 1'b1; out_ready = 1'b0;
        tick(); EN_enc = 1'b0; req_in = 8'h00;
        tick();
        @(negedge CLK);
        check("bp_held_idx", out_idx, 7);
        check("bp_count2",   pend_count, 2);
        tick(); req_in = 8'h82; EN_enc = 1'b1;
        tick(); EN_enc = 1'b0; req_in = 8'h00;
        repeat (2) tick();
        @(negedge CLK);
        check("bp_still_idx", out_idx, 7);
        check("bp_count4",    pend_count, 4);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge CLK);
            check("bp_idx",  out_idx,  bpexp[k]);
            check("bp_last", out_last, (k == 3));
        end
        tick();
        @(negedge CLK);
        check("bp_done", out_valid, 0);

        // Continuous re-request of lines 7 and 0.
        tick(); req_in = 8'h81; EN_enc = 1'b1; out_ready = 1'b1;
        repeat (4) tick();
        prev = -1;
        for (int k = 0; k < 6; k++) begin
            tick();
            @(negedge CLK);
            cur = int'(out_idx);
`ifdef PENC_RR_EN
            check("rr_member", (cur == 7 || cur == 0), 1);
            if (k > 0) check("rr_alternate", (cur != prev), 1);
`else
            check("fixed_starve", cur, 7);
`endif
            prev = cur;
        end
        tick(); EN_enc = 1'b0; req_in = 8'h00;
        repeat (4) tick();

        // Reset in the middle of a burst.
        tick(); req_in = 8'h85; EN_enc = 1'b1; out_ready = 1'b0;
        tick(); EN_enc = 1'b0; req_in = 8'h00;
        tick();
        @(negedge CLK);
        check("mid_count2", pend_count, 2);
        check("mid_valid",  out_valid,  1);
        tick(); RST = 1'b1; out_ready = 1'b1;
        tick(); RST = 1'b0; out_ready = 1'b0;
        @(negedge CLK);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_idx",   out_idx,   0);
        check("mid_rst_last",  out_last,  0);
        check("mid_rst_count", pend_count, 0);
        tick(); req_in = 8'h08; EN_enc = 1'b1;
        tick(); EN_enc = 1'b0; req_in = 8'h00;
        tick();
        @(negedge CLK);
        check("mid_new_idx",  out_idx,  3);
        check("mid_new_last", out_last, 1);
        check("mid_new_count", pend_count, 0);
        tick(); out_ready = 1'b1;
        tick();
        @(negedge CLK);
        check("mid_new_done", out_valid, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            tick();
            RST       = ($urandom_range(0, 199) == 0);
            EN_enc    = $urandom_range(0, 1) == 1;
            req_in    = 8'($urandom & $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        RST = 1'b0; EN_enc = 1'b0; out_ready = 1'b1;
        repeat (12) tick();
        @(negedge CLK);
        check("final_drained", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
